axis_frame_pad: RTL
===================

# axis_frame_pad

AXI4-Stream frame length conditioner placed directly downstream of the bus width adapter on the transmit path. It zero-pads frames shorter than `MIN_LEN` bytes and, when truncation is compiled in, cuts frames longer than `MAX_LEN` bytes and flags them as errored. Output is fully registered. It reports per-frame length and status.

## Interface
- `DATA_WIDTH`, 64: tdata width in bits.
- `KEEP_ENABLE`, `(DATA_WIDTH>8)`: propagate tkeep. If 0, every lane is treated as valid.
- `KEEP_WIDTH`, `((DATA_WIDTH+7)/8)`: byte lanes.
- `ID_ENABLE`/`ID_WIDTH`, 0/8: tid propagation and width.
- `DEST_ENABLE`/`DEST_WIDTH`, 0/8: tdest propagation and width.
- `USER_ENABLE`/`USER_WIDTH`, 1/1: tuser propagation and width.
- `MIN_LEN`, 60: minimum output frame length in bytes. Must be ≥1.
- `MAX_LEN`, 1518: maximum frame length in bytes. Must be ≥ `MIN_LEN`.
- `LEN_WIDTH`, 16: byte counter width. Must hold `MAX_LEN+KEEP_WIDTH`.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `s_axis_tdata/tkeep/tvalid/tlast/tid/tdest/tuser`, inputs with widths per parameters; `s_axis_tready` output 1.
- `m_axis_tdata/tkeep/tvalid/tlast/tid/tdest/tuser`, outputs with widths per parameters; `m_axis_tready` input 1.
- `stat_frame_len` output `LEN_WIDTH`: byte count of the last emitted frame.
- `stat_pad` output 1: last frame was padded.
- `stat_trunc` output 1: last frame was truncated.
- `stat_valid` output 1: one-cycle strobe; stat_* fields are updated with it.

## Operation
- tkeep is contiguous from lane 0. Only a tlast beat may be partial. Beat byte count is popcount(tkeep).
- `cnt` holds the bytes already emitted for the current frame and is cleared after each output tlast.
- Output register loads when `!m_axis_tvalid || m_axis_tready`. `s_axis_tready` = load condition AND state≠PAD. In DROP, `s_axis_tready` = 1.
- States:
  - **PASS** (reset state): forward beats.
    - Input tlast with `cnt+n ≥ MIN_LEN`: forward unchanged, tlast=1.
    - Input tlast with `cnt+n < MIN_LEN`: zero lanes above n. Raise tkeep up to min(KEEP_WIDTH, MIN_LEN−cnt) lanes. If that reaches MIN_LEN, tlast=1; else tlast=0 and go to PAD.
  - **PAD**: emit all-zero data beats, holding tid/tdest/tuser of the last input beat. The beat reaching MIN_LEN has partial tkeep and tlast=1, then return to PASS.
  - **DROP** (truncation only): accept and discard input. Go to PASS on the input tlast transfer. Nothing is emitted.
- Stat strobe fires on the cycle the output tlast beat is loaded into the output register. `stat_frame_len` = final byte count; `stat_pad`/`stat_trunc` set accordingly.
- Disabled tid/tdest/tuser outputs are driven 0. When `KEEP_ENABLE`=0, `m_axis_tkeep` is all ones, and `MIN_LEN` and `MAX_LEN` must be multiples of `KEEP_WIDTH`.

## Timing
- Reset values: m_axis_tvalid=0, s_axis_tready=1, stat_valid=0, stat_pad=0, stat_trunc=0, stat_frame_len=0, state=PASS, cnt=0. Data registers are unreset.
- Latency is 1 cycle from input transfer to m_axis_tvalid.
- Throughput is 1 beat per cycle in PASS. PAD inserts `ceil((MIN_LEN−cnt)/KEEP_WIDTH)−1` beats with s_axis_tready=0.
- m_axis_tvalid/tdata stay stable while `m_axis_tready`=0.
- Reset mid-frame in any state: m_axis_tvalid=0 on the next edge; the partial frame is abandoned. The next beat starts a new frame with cnt=0.
- An input tlast on the beat that hits exactly MAX_LEN is a normal frame: no truncation, no DROP.

## Configuration
- Macro `AXIS_FRAME_PAD_TRUNC_EN`.
- **Defined:** truncation is active. When `cnt+n > MAX_LEN` and the beat is not tlast:
  - emit the beat with tkeep limited to `MAX_LEN−cnt` lanes, tlast=1 and tuser[0]=1;
  - set stat_trunc and enter DROP.
  - A tlast beat exceeding MAX_LEN is also cut and flagged, with no DROP.
- **Undefined:** DROP does not exist, `MAX_LEN` is ignored, and `cnt` saturates at all ones. stat_trunc is tied to 0.

## Test plan
- 14-byte frame (tkeep FF, 3F), 64-bit, MIN_LEN 60, m_ready=1 → 8 output beats:
  - beat1 bytes 6–7 are zero with tkeep FF;
  - beats 2–6 are zero with tkeep FF;
  - beat7 has tkeep 0F and tlast;
  - stat_frame_len=60, stat_pad=1.
- 64-byte frame → 8 beats identical to the input, stat_pad=0, stat_frame_len=64.
- 1600-byte frame with TRUNC_EN → 190 beats; beat 189 has tkeep 3F, tlast=1, tuser[0]=1. All remaining input is accepted with no output; stat_frame_len=1518, stat_trunc=1.
- Scenario 1 with m_axis_tready toggled every cycle → identical output beats, no loss or duplication, data stable while stalled.
- Reset asserted during PAD → m_axis_tvalid=0 next cycle. A following 64-byte frame is output intact, with stat_frame_len=64.
- Back-to-back 64-byte and 14-byte frames, s_valid held high → first frame at 1 beat/cycle; s_axis_tready low for 6 cycles during the second frame's padding.

Source files
------------

// File: rtl/axis_frame_pad.sv
// -----------------------------------------------------------------------------
// axis_frame_pad
//
// AXI4-Stream frame length conditioner for the transmit path. Frames shorter
// than MIN_LEN bytes are zero-padded up to MIN_LEN. When the macro
// AXIS_FRAME_PAD_TRUNC_EN is defined, frames longer than MAX_LEN bytes are cut
// at MAX_LEN, flagged with tuser[0]=1, and the rest of the input frame is
// discarded. Without the macro, MAX_LEN is ignored and the byte counter
// saturates. The output stage is a single register slice.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   s_axis_*             input stream (tdata/tkeep/tvalid/tready/tlast/tid/
//                        tdest/tuser)
//   m_axis_*             output stream, fully registered
//   stat_frame_len       byte count of the last emitted frame
//   stat_pad             last emitted frame was padded
//   stat_trunc           last emitted frame was truncated
//   stat_valid           one-cycle strobe, stat_* updated with it
//   dbg_state_o          current FSM state (0 PASS, 1 PAD, 2 DROP)
//
// Handshake: a beat transfers on any edge where tvalid && tready are both
// high; tvalid, once raised, holds with stable payload until that edge.
// -----------------------------------------------------------------------------
module axis_frame_pad #(
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int MIN_LEN     = 60,
  parameter int MAX_LEN     = 1518,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  output logic [LEN_WIDTH-1:0]  stat_frame_len,
  output logic                  stat_pad,
  output logic                  stat_trunc,
  output logic                  stat_valid,

  output logic [1:0]            dbg_state_o
);

  // Elaboration-time parameter sanity checks.
  if (MIN_LEN < 1) begin : g_chk_min
    $error("axis_frame_pad: MIN_LEN must be >= 1");
  end
  if (MAX_LEN < MIN_LEN) begin : g_chk_max
    $error("axis_frame_pad: MAX_LEN must be >= MIN_LEN");
  end
  if ((MAX_LEN + KEEP_WIDTH) >= (1 << LEN_WIDTH)) begin : g_chk_len
    $error("axis_frame_pad: LEN_WIDTH too small for MAX_LEN+KEEP_WIDTH");
  end
  if ((KEEP_ENABLE == 0) && (((MIN_LEN % KEEP_WIDTH) != 0) || ((MAX_LEN % KEEP_WIDTH) != 0)))
  begin : g_chk_keep
    $error("axis_frame_pad: MIN_LEN/MAX_LEN must be multiples of KEEP_WIDTH without tkeep");
  end

  // One extra bit so cnt+n never wraps during comparisons.
  typedef logic [LEN_WIDTH:0] ext_t;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_PAD  = 2'd1
`ifdef AXIS_FRAME_PAD_TRUNC_EN
    ,
    ST_DROP = 2'd2
`endif
  } state_t;

  localparam ext_t MIN_E = ext_t'(MIN_LEN);
  localparam ext_t KW_E  = ext_t'(KEEP_WIDTH);
`ifdef AXIS_FRAME_PAD_TRUNC_EN
  localparam ext_t MAX_E = ext_t'(MAX_LEN);
`endif

  function automatic logic [KEEP_WIDTH-1:0] lane_mask(input ext_t lanes);
    logic [KEEP_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) m[i] = (ext_t'(i) < lanes);
    return m;
  endfunction

  function automatic ext_t pop_count(input logic [KEEP_WIDTH-1:0] k);
    ext_t c;
    c = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) c = c + ext_t'(k[i]);
    return c;
  endfunction

  // Expand a lane mask to a bit mask (lane i covers bits 8i..8i+7).
  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [KEEP_WIDTH-1:0] k);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int b = 0; b < DATA_WIDTH; b++) m[b] = k[b/8];
    return m;
  endfunction

  function automatic logic [LEN_WIDTH-1:0] sat_len(input ext_t v);
    return v[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : v[LEN_WIDTH-1:0];
  endfunction

  state_t                 state_q;
  logic [LEN_WIDTH-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0]  tdata_q;
  logic [KEEP_WIDTH-1:0]  tkeep_q;
  logic                   tvalid_q;
  logic                   tlast_q;
  logic [ID_WIDTH-1:0]    tid_q;
  logic [DEST_WIDTH-1:0]  tdest_q;
  logic [USER_WIDTH-1:0]  tuser_q;
  logic [LEN_WIDTH-1:0]   stat_len_q;
  logic                   stat_pad_q;
  logic                   stat_trunc_q;
  logic                   stat_valid_q;

  logic [KEEP_WIDTH-1:0]  keep_in;
  ext_t                   in_n;
  ext_t                   sum;
  ext_t                   need;
  logic                   load;
  logic                   in_xfer;
`ifdef AXIS_FRAME_PAD_TRUNC_EN
  ext_t                   room;
`endif

  always_comb begin
    keep_in = (KEEP_ENABLE != 0) ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};
    in_n    = pop_count(keep_in);
    sum     = ext_t'(cnt_q) + in_n;
    // Bytes still missing to reach MIN_LEN; only consulted while cnt < MIN_LEN.
    need    = MIN_E - ext_t'(cnt_q);
    load    = !tvalid_q || m_axis_tready;
`ifdef AXIS_FRAME_PAD_TRUNC_EN
    room    = MAX_E - ext_t'(cnt_q);
`endif
  end

`ifdef AXIS_FRAME_PAD_TRUNC_EN
  // DROP always sinks input, even while the output slice is stalled.
  assign s_axis_tready = (state_q == ST_DROP) ? 1'b1 : (load && (state_q != ST_PAD));
`else
  assign s_axis_tready = load && (state_q != ST_PAD);
`endif
  assign in_xfer = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_PASS;
      cnt_q        <= '0;
      tvalid_q     <= 1'b0;
      stat_len_q   <= '0;
      stat_pad_q   <= 1'b0;
      stat_trunc_q <= 1'b0;
      stat_valid_q <= 1'b0;
    end else begin
      stat_valid_q <= 1'b0;
      case (state_q)
        ST_PASS: begin
          if (load) begin
            if (in_xfer) begin
              tvalid_q <= 1'b1;
              tdata_q  <= s_axis_tdata;
              tkeep_q  <= keep_in;
              tlast_q  <= s_axis_tlast;
              tid_q    <= s_axis_tid;
              tdest_q  <= s_axis_tdest;
              tuser_q  <= s_axis_tuser;
`ifdef AXIS_FRAME_PAD_TRUNC_EN
              if (sum > MAX_E) begin
                // Cut at MAX_LEN and mark the frame bad.
                tkeep_q      <= lane_mask(room);
                tdata_q      <= s_axis_tdata & byte_mask(lane_mask(room));
                tlast_q      <= 1'b1;
                tuser_q      <= s_axis_tuser | USER_WIDTH'(1);
                stat_len_q   <= LEN_WIDTH'(MAX_LEN);
                stat_pad_q   <= 1'b0;
                stat_trunc_q <= 1'b1;
                stat_valid_q <= 1'b1;
                cnt_q        <= '0;
                if (!s_axis_tlast) state_q <= ST_DROP;
              end else
`endif
              if (s_axis_tlast) begin
                if (sum >= MIN_E) begin
                  stat_len_q   <= sat_len(sum);
                  stat_pad_q   <= 1'b0;
                  stat_trunc_q <= 1'b0;
                  stat_valid_q <= 1'b1;
                  cnt_q        <= '0;
                end else begin
                  // Short tail: blank unused lanes and widen tkeep toward MIN_LEN.
                  tdata_q <= s_axis_tdata & byte_mask(lane_mask(in_n));
                  if (need <= KW_E) begin
                    tkeep_q      <= lane_mask(need);
                    stat_len_q   <= LEN_WIDTH'(MIN_LEN);
                    stat_pad_q   <= 1'b1;
                    stat_trunc_q <= 1'b0;
                    stat_valid_q <= 1'b1;
                    cnt_q        <= '0;
                  end else begin
                    tkeep_q <= {KEEP_WIDTH{1'b1}};
                    tlast_q <= 1'b0;
                    cnt_q   <= cnt_q + LEN_WIDTH'(KEEP_WIDTH);
                    state_q <= ST_PAD;
                  end
                end
              end else begin
                cnt_q <= sat_len(sum);
              end
            end else begin
              tvalid_q <= 1'b0;
            end
          end
        end

        ST_PAD: begin
          // tid/tdest/tuser are left untouched so they hold the last input beat.
          if (load) begin
            tvalid_q <= 1'b1;
            tdata_q  <= '0;
            if (need <= KW_E) begin
              tkeep_q      <= lane_mask(need);
              tlast_q      <= 1'b1;
              stat_len_q   <= LEN_WIDTH'(MIN_LEN);
              stat_pad_q   <= 1'b1;
              stat_trunc_q <= 1'b0;
              stat_valid_q <= 1'b1;
              cnt_q        <= '0;
              state_q      <= ST_PASS;
            end else begin
              tkeep_q <= {KEEP_WIDTH{1'b1}};
              tlast_q <= 1'b0;
              cnt_q   <= cnt_q + LEN_WIDTH'(KEEP_WIDTH);
            end
          end
        end

`ifdef AXIS_FRAME_PAD_TRUNC_EN
        ST_DROP: begin
          if (load) tvalid_q <= 1'b0;
          if (in_xfer && s_axis_tlast) state_q <= ST_PASS;
        end
`endif

        default: state_q <= ST_PASS;
      endcase
    end
  end

  assign m_axis_tdata   = tdata_q;
  assign m_axis_tkeep   = (KEEP_ENABLE != 0) ? tkeep_q : {KEEP_WIDTH{1'b1}};
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tlast_q;
  assign m_axis_tid     = (ID_ENABLE   != 0) ? tid_q   : '0;
  assign m_axis_tdest   = (DEST_ENABLE != 0) ? tdest_q : '0;
  assign m_axis_tuser   = (USER_ENABLE != 0) ? tuser_q : '0;

  assign stat_frame_len = stat_len_q;
  assign stat_pad       = stat_pad_q;
  assign stat_trunc     = stat_trunc_q;
  assign stat_valid     = stat_valid_q;
  assign dbg_state_o    = state_q;

endmodule
